// File: rtl/my_arb_pkg.sv
// Shared types and helpers for the four-requester round-robin arbiter.
package my_arb_pkg;

  localparam int N_REQ  = 4;
  localparam int WORD_W = 16;

  typedef logic [1:0] src_t;

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } arb_state_t;

  // Cyclic successor of a requester index; the 2-bit result wraps 3 -> 0.
  function automatic src_t next_src(input src_t g);
    return src_t'(g + 2'd1);
  endfunction

endpackage

// File: rtl/my_mux_16.sv
// 2:1 selector for one 16-bit word; three of these form the 4:1 data select.
module my_mux_16
  import my_arb_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              sel,
  output logic [WORD_W-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/my_rr_pick.sv
// Rotated priority encoder: first asserted request at or after ptr, scanning cyclically.
module my_rr_pick
  import my_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  src_t             ptr,
  output logic [N_REQ-1:0] gnt,
  output src_t             g
);

  logic found;
  src_t idx;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt   = '0;
    g     = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = ptr + src_t'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        g     = idx;
      end
    end
    if (found) gnt[g] = 1'b1;
  end

endmodule

// File: rtl/my_rr_arbiter_16.sv
// Round-robin arbiter of four 16-bit requesters onto one registered valid/ready output.
// Optional burst re-grant is compiled in with `define MY_RR_ARBITER_BURST_EN.
module my_rr_arbiter_16
  import my_arb_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*WORD_W-1:0] in_data,
  output logic [N_REQ-1:0]        in_ack,
  output logic                    out_valid,
  output logic [WORD_W-1:0]       out_data,
  output src_t                    out_src,
  input  logic                    out_ready
);

  if (MAX_BURST < 1) begin : g_bad_max_burst
    $error("MAX_BURST must be at least 1");
  end

  arb_state_t        state_q;
  logic [WORD_W-1:0] data_q;
  src_t              src_q;
  src_t              ptr_q, ptr_d;
  src_t              g;
  src_t              rr_g;
  logic [N_REQ-1:0]  rr_gnt;
  logic [N_REQ-1:0]  gnt;
  logic              load;
  logic [WORD_W-1:0] mux_lo, mux_hi, sel_word;

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_src   = src_q;

  assign load   = (|req) && (!out_valid || out_ready) && !reset;
  assign in_ack = load ? gnt : '0;

  my_rr_pick u_pick (
    .req (req),
    .ptr (ptr_q),
    .gnt (rr_gnt),
    .g   (rr_g)
  );

`ifdef MY_RR_ARBITER_BURST_EN
  localparam int CNT_W = ($clog2(MAX_BURST) > 0) ? $clog2(MAX_BURST) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  src_t             last_q;
  logic             has_last_q;
  logic             burst;

  // Re-grant the last winner ahead of rotation while it keeps requesting and has burst budget.
  assign burst = has_last_q && req[last_q] && (int'(cnt_q) < MAX_BURST - 1);
  assign g     = burst ? last_q : rr_g;
  assign gnt   = burst ? ({{(N_REQ-1){1'b0}}, 1'b1} << last_q) : rr_gnt;

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (!req[last_q]) cnt_d = '0;
    if (load) begin
      if (burst) begin
        cnt_d = cnt_q + 1'b1;
      end else begin
        ptr_d = next_src(rr_g);
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      last_q     <= '0;
      has_last_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (load) begin
        last_q     <= g;
        has_last_q <= 1'b1;
      end
    end
  end
`else
  assign g     = rr_g;
  assign gnt   = rr_gnt;
  assign ptr_d = load ? next_src(rr_g) : ptr_q;
`endif

  my_mux_16 u_mux_lo (
    .a   (in_data[0*WORD_W +: WORD_W]),
    .b   (in_data[1*WORD_W +: WORD_W]),
    .sel (g[0]),
    .y   (mux_lo)
  );

  my_mux_16 u_mux_hi (
    .a   (in_data[2*WORD_W +: WORD_W]),
    .b   (in_data[3*WORD_W +: WORD_W]),
    .sel (g[0]),
    .y   (mux_hi)
  );

  my_mux_16 u_mux_out (
    .a   (mux_lo),
    .b   (mux_hi),
    .sel (g[1]),
    .y   (sel_word)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      src_q   <= '0;
      ptr_q   <= '0;
    end else begin
      ptr_q <= ptr_d;
      case (state_q)
        IDLE: begin
          if (load) begin
            state_q <= FULL;
            data_q  <= sel_word;
            src_q   <= g;
          end
        end
        FULL: begin
          if (load) begin
            data_q <= sel_word;
            src_q  <= g;
          end else if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_my_rr_arbiter_16.sv
// Self-checking bench for my_rr_arbiter_16: vector table, corner sequences, randomized model check.
module tb_my_rr_arbiter_16;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [63:0] in_data;
  logic [3:0]  in_ack;
  logic        out_valid;
  logic [15:0] out_data;
  logic [1:0]  out_src;
  logic        out_ready;

  int n_cmp;
  int n_bad;

  my_rr_arbiter_16 #(.MAX_BURST(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .in_data   (in_data),
    .in_ack    (in_ack),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle: drive inputs, check the combinational ack, clock, check registered outputs.
  task automatic step(input string tag, input logic [3:0] r, input logic [63:0] d,
                      input logic rdy, input logic [3:0] e_ack, input logic e_v,
                      input logic [15:0] e_d, input logic [1:0] e_s);
    req = r; in_data = d; out_ready = rdy;
    #1;
    check({tag, ".ack"}, 32'(in_ack), 32'(e_ack));
    @(posedge clk); #1;
    check({tag, ".valid"}, 32'(out_valid), 32'(e_v));
    check({tag, ".data"}, 32'(out_data), 32'(e_d));
    check({tag, ".src"}, 32'(out_src), 32'(e_s));
  endtask

  task automatic do_reset();
    req = '0; out_ready = 1'b0; in_data = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  r;
    logic        rdy;
    logic [3:0]  ack;
    logic        v;
    logic [15:0] d;
    logic [1:0]  s;
  } vec_t;

  localparam logic [63:0] WORDS = {16'h3333, 16'hBEEF, 16'h1111, 16'h1000};

  // Reference model state: plain integers, following the arbitration rules directly.
  int          m_ptr, m_last, m_cnt, m_src;
  bit          m_has_last, m_valid;
  logic [15:0] m_data;

  initial begin
    vec_t vt[$];
    n_cmp = 0;
    n_bad = 0;
    do_reset();

    check("reset.valid", 32'(out_valid), 32'd0);
    check("reset.data", 32'(out_data), 32'd0);

`ifndef MY_RR_ARBITER_BURST_EN
    vt.push_back('{4'b0100, 1'b1, 4'b0100, 1'b1, 16'hBEEF, 2'd2});
    vt.push_back('{4'b0000, 1'b1, 4'b0000, 1'b0, 16'hBEEF, 2'd2});
    vt.push_back('{4'b1111, 1'b1, 4'b1000, 1'b1, 16'h3333, 2'd3});
    vt.push_back('{4'b1111, 1'b1, 4'b0001, 1'b1, 16'h1000, 2'd0});
    vt.push_back('{4'b1111, 1'b1, 4'b0010, 1'b1, 16'h1111, 2'd1});
    vt.push_back('{4'b1111, 1'b1, 4'b0100, 1'b1, 16'hBEEF, 2'd2});
    vt.push_back('{4'b1111, 1'b1, 4'b1000, 1'b1, 16'h3333, 2'd3});
    vt.push_back('{4'b1111, 1'b1, 4'b0001, 1'b1, 16'h1000, 2'd0});
    vt.push_back('{4'b0011, 1'b0, 4'b0000, 1'b1, 16'h1000, 2'd0});
    vt.push_back('{4'b0011, 1'b0, 4'b0000, 1'b1, 16'h1000, 2'd0});
    vt.push_back('{4'b0011, 1'b0, 4'b0000, 1'b1, 16'h1000, 2'd0});
    vt.push_back('{4'b0011, 1'b1, 4'b0010, 1'b1, 16'h1111, 2'd1});
    vt.push_back('{4'b0011, 1'b1, 4'b0001, 1'b1, 16'h1000, 2'd0});
    vt.push_back('{4'b0000, 1'b0, 4'b0000, 1'b1, 16'h1000, 2'd0});
    vt.push_back('{4'b0000, 1'b1, 4'b0000, 1'b0, 16'h1000, 2'd0});
    vt.push_back('{4'b1000, 1'b0, 4'b1000, 1'b1, 16'h3333, 2'd3});
    foreach (vt[i])
      step($sformatf("vec%0d", i), vt[i].r, WORDS, vt[i].rdy, vt[i].ack, vt[i].v, vt[i].d, vt[i].s);
`endif

    // Reset asserted mid-cycle while FULL must clear outputs and ack without a clock edge.
    step("fill", 4'b0001, WORDS, 1'b1, 4'b0001, 1'b1, 16'h1000, 2'd0);
    req = 4'b1111; out_ready = 1'b0;
    #3 reset = 1'b1;
    #1;
    check("async_rst.valid", 32'(out_valid), 32'd0);
    check("async_rst.data", 32'(out_data), 32'd0);
    check("async_rst.src", 32'(out_src), 32'd0);
    check("async_rst.ack", 32'(in_ack), 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // Two requesters held after reset: grant order starts from pointer 0.
`ifdef MY_RR_ARBITER_BURST_EN
    for (int i = 0; i < 9; i++) begin
      logic [3:0]  ea;
      logic [15:0] ed;
      ea = (i >= 4 && i < 8) ? 4'b0010 : 4'b0001;
      ed = (i >= 4 && i < 8) ? 16'h1111 : 16'h1000;
      step($sformatf("burst%0d", i), 4'b0011, WORDS, 1'b1, ea, 1'b1, ed, (i >= 4 && i < 8) ? 2'd1 : 2'd0);
    end
`else
    for (int i = 0; i < 4; i++)
      step($sformatf("alt%0d", i), 4'b0011, WORDS, 1'b1, i[0] ? 4'b0010 : 4'b0001,
           1'b1, i[0] ? 16'h1111 : 16'h1000, i[0] ? 2'd1 : 2'd0);
`endif

    // Randomized traffic against the reference model.
    do_reset();
    m_ptr = 0; m_last = 0; m_cnt = 0; m_has_last = 0;
    m_valid = 0; m_data = '0; m_src = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      int  g;
      bit  load, bursting;
      logic [3:0] exp_ack;
      req       = 4'($urandom_range(0, 15));
      in_data   = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);

      load     = (req != 0) && (!m_valid || out_ready);
      bursting = 0;
      g        = -1;
`ifdef MY_RR_ARBITER_BURST_EN
      if (!req[m_last]) m_cnt = 0;
      if (m_has_last && req[m_last] && m_cnt < 4 - 1) begin
        bursting = 1;
        g = m_last;
      end
`endif
      if (g < 0)
        for (int k = 0; k < 4; k++)
          if (g < 0 && req[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
      exp_ack = load ? 4'(1 << g) : 4'b0000;

      #1;
      check("rand.ack", 32'(in_ack), 32'(exp_ack));

      if (load) begin
        m_data  = in_data[16*g +: 16];
        m_src   = g;
        m_valid = 1;
        if (bursting) m_cnt++;
        else begin
          m_ptr = (g + 1) % 4;
          m_cnt = 0;
        end
        m_last     = g;
        m_has_last = 1;
      end else if (out_ready) begin
        m_valid = 0;
      end

      @(posedge clk); #1;
      check("rand.valid", 32'(out_valid), 32'(m_valid));
      check("rand.data", 32'(out_data), 32'(m_data));
      check("rand.src", 32'(out_src), 32'(m_src));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/my_rr_arbiter_16.md
# my_rr_arbiter_16

Round-robin arbiter that shares one registered 16-bit output channel among four requesters. Each cycle it picks at most one pending requester, steers that requester's word through a 4:1 tree of `my_mux_16` instances, and loads it into an output register drained by a valid/ready handshake. It is the sequencing block in front of any single-consumer 16-bit datapath, such as a memory write port or ALU input, that several sources must share.

## Interface
- `MAX_BURST`, default 4: maximum consecutive grants to one requester; used only when bursting is compiled in (see Configuration).
- `clk`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  4  `req[i]` high means requester i presents a valid word.
- `in_data`  in  64  word of requester i at bits `[16*i+15:16*i]`.
- `in_ack`  out  4  one-hot, combinational; `in_ack[i]` high means requester i's word is taken this cycle.
- `out_valid`  out  1  output register holds a word.
- `out_data`  out  16  registered word.
- `out_src`  out  2  index of the requester that supplied `out_data`.
- `out_ready`  in  1  consumer accepts `out_data` this cycle.

## Operation
- **States:** IDLE (`out_valid`=0) and FULL (`out_valid`=1).
- **Load condition:** `load = |req && (!out_valid || out_ready)`.
- **Grant:** when `load` is high, grant g is the first asserted `req` at or after `ptr`, scanning cyclically from `ptr` (0→1→2→3→0). Drive `in_ack[g]`=1 and all other `in_ack` bits 0.
- **On a `load` edge:**
  - `out_data` ← word g
  - `out_src` ← g
  - `out_valid` ← 1
  - `ptr` ← (g+1) mod 4
- **Drain without refill:** `out_ready` high with no pending `req` sets `out_valid` ← 0. `out_data` and `out_src` hold their last values.
- **Backpressure:** FULL with `out_ready`=0 gives no grant. `in_ack`=0, and the register and `ptr` hold.
- **Requester contract:** hold `req` and data stable until `in_ack`. A requester may keep `req` high to present its next word in the following cycle. Dropping `req` before `in_ack` withdraws the word; the arbiter ignores the word.
- **Simultaneous drain and load:** the old word leaves and the new word enters on the same edge, so `out_valid` stays 1.
- **Fairness:** any continuously asserted requester is granted within 4 grants.
- **Reset:** async assert sets `out_valid`=0, `out_data`=16'h0000, `out_src`=0, `ptr`=0, burst count=0. `in_ack` is forced to 0 while `reset` is high. A word in flight at reset is discarded; requesters must re-present it.

## Timing
- Latency: a word acked in cycle t appears on `out_data` with `out_valid` in cycle t+1.
- Throughput: 1 word/cycle when `out_ready` is held high.
- `in_ack` is combinational from `req`, `out_valid`, `out_ready` and `ptr`. There is no combinational path from `in_data` to any output.
- `out_*` change only on the `clk` edge or on `reset`.

## Configuration
- **Macro `MY_RR_ARBITER_BURST_EN` defined:**
  - If the last-granted requester still has `req` high and its burst count is below MAX_BURST−1, it is re-granted ahead of the rotation. The burst count increments and `ptr` does not advance.
  - When the requester drops `req` or reaches MAX_BURST grants, normal rotation resumes and the count clears.
  - Worst-case wait becomes 3×MAX_BURST grants.
- **Macro not defined:** strict one-word round-robin as in Operation. The burst counter and `MAX_BURST` logic are not synthesized.

## Structure
- **Package `my_arb_pkg` contains:**
  - `N_REQ`=4 and `WORD_W`=16
  - typedef `src_t` (2-bit requester index)
  - enum `arb_state_t` {IDLE, FULL}
  - a function computing (g+1) mod 4
- **Sub-module `my_rr_pick`:** combinational rotated priority encoder. Inputs `req[3:0]` and `ptr`; outputs `gnt` (one-hot) and `g` (index).
- **Data select:** three `my_mux_16` instances form the 4:1 select, with `sel` bits taken from `g`.

## Test plan
- **Reset:** reset high mid-FULL → `out_valid`=0, `out_data`=16'h0000 and `in_ack`=0 immediately, without waiting for a clock edge.
- **Single requester:** `req`=4'b0100, word2=16'hBEEF, `out_ready`=1 → `in_ack`=4'b0100 in cycle t; in t+1, `out_valid`=1, `out_data`=16'hBEEF, `out_src`=2.
- **Rotation:** all four `req` held, `out_ready`=1 → grant order 0,1,2,3,0 on consecutive cycles, one word per cycle.
- **Backpressure:** FULL with `out_ready`=0 for 3 cycles while `req`=4'b0011 → `in_ack`=0 and `out_data` stable. When `out_ready` rises, the next grant follows `ptr`.
- **Drain to IDLE:** `req`=0, FULL, `out_ready`=1 → next cycle `out_valid`=0 and `out_data` unchanged.
- **Burst (macro defined):** MAX_BURST=4, `req`=4'b0011 held → grants 0,0,0,0,1,1,1,1,0. Same stimulus with the macro undefined → grants 0,1,0,1.
